// File: rtl/spi_dac_rx_if.sv
// spi_dac_rx_if: SPI DAC pins plus the decoded-frame valid/ready port and DAC register outputs.
interface spi_dac_rx_if #(parameter int DATA_BITS = 16);
    logic                 cs_i;
    logic                 scl_i;
    logic                 mosi_i;
    logic                 ldac_i;
    logic                 frame_ready_i;
    logic                 frame_valid_o;
    logic [3:0]           cmd_o;
    logic [3:0]           addr_o;
    logic [DATA_BITS-1:0] data_o;
    logic                 frame_err_o;
    logic                 overrun_o;
    logic [DATA_BITS-1:0] dac_reg_o;
    logic                 dac_update_o;
    modport slave (
        input  cs_i, scl_i, mosi_i, ldac_i, frame_ready_i,
        output frame_valid_o, cmd_o, addr_o, data_o, frame_err_o, overrun_o, dac_reg_o, dac_update_o
    );
    modport master (
        output cs_i, scl_i, mosi_i, ldac_i, frame_ready_i,
        input  frame_valid_o, cmd_o, addr_o, data_o, frame_err_o, overrun_o, dac_reg_o, dac_update_o
    );
endinterface

// File: rtl/spi_dac_rx.sv
// spi_dac_rx: oversampled SPI DAC frame receiver with input/output DAC registers.
// Define SPI_DAC_RX_LDAC_EN to let a falling ldac_i copy input_reg into dac_reg.
module spi_dac_rx #(
    parameter int FRAME_BITS = 24,
    parameter int DATA_BITS  = 16
) (
    input  logic         sys_clk_i,
    input  logic         sys_rst,
    spi_dac_rx_if.slave  bus
);
    typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT, CHECK} state_t;
    state_t r_state, w_next;
    logic r_cs_s1, r_cs_s2, r_cs_s3, r_scl_s1, r_scl_s2, r_scl_s3, r_mosi_s1, r_mosi_s2;
    logic [FRAME_BITS-1:0] r_shift;
    logic [4:0]            r_cnt;
    logic                  r_valid, r_err, r_ovr, r_upd;
    logic [3:0]            r_cmd, r_addr;
    logic [DATA_BITS-1:0]  r_data, r_input, r_dac;
    logic w_cs_fall, w_cs_rise, w_scl_rise, w_clr, w_shift, w_check;
    logic w_good, w_load, w_cmd_dac, w_dac_wr, w_ldac_fall;
    logic [3:0]           w_cmd;
    logic [DATA_BITS-1:0] w_data, w_dac_nxt;

    assign w_cs_fall  = r_cs_s3 & ~r_cs_s2;
    assign w_cs_rise  = ~r_cs_s3 & r_cs_s2;
    assign w_scl_rise = ~r_scl_s3 & r_scl_s2;
    assign w_cmd      = r_shift[FRAME_BITS-1 -: 4];
    assign w_data     = r_shift[DATA_BITS-1:0];
    assign w_good     = w_check && (r_cnt == 5'(FRAME_BITS));
    assign w_load     = w_good && (!r_valid || bus.frame_ready_i);
    assign w_cmd_dac  = w_good && (w_cmd == 4'h2 || w_cmd == 4'h3);
    assign w_dac_wr   = w_cmd_dac || w_ldac_fall;
    assign w_dac_nxt  = (w_cmd_dac && w_cmd == 4'h3) ? w_data : r_input;

`ifdef SPI_DAC_RX_LDAC_EN
    logic r_ldac_s1, r_ldac_s2, r_ldac_s3;
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst) begin
            {r_ldac_s1, r_ldac_s2, r_ldac_s3} <= '0;
        end else begin
            {r_ldac_s1, r_ldac_s2, r_ldac_s3} <= {bus.ldac_i, r_ldac_s1, r_ldac_s2};
        end
    end
    assign w_ldac_fall = r_ldac_s3 & ~r_ldac_s2;
`else
    assign w_ldac_fall = 1'b0;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst) r_state <= WAIT_HI;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_clr   = 1'b0;
        w_shift = 1'b0;
        w_check = 1'b0;
        case (r_state)
            WAIT_HI: w_next = r_cs_s2 ? IDLE : WAIT_HI;
            IDLE: begin
                w_clr  = w_cs_fall;
                w_next = w_cs_fall ? SHIFT : IDLE;
            end
            SHIFT: begin
                w_shift = w_scl_rise;
                w_next  = w_cs_rise ? CHECK : SHIFT;
            end
            default: begin
                w_check = 1'b1;
                w_next  = IDLE;
            end
        endcase
    end

    // cs synchronizer resets low so a frame cut by reset is not mistaken for a new cs fall
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst) begin
            {r_cs_s1, r_cs_s2, r_cs_s3}    <= '0;
            {r_scl_s1, r_scl_s2, r_scl_s3} <= '0;
            {r_mosi_s1, r_mosi_s2}         <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ovr   <= 1'b0;
            r_upd   <= 1'b0;
            r_cmd   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_input <= '0;
            r_dac   <= '0;
        end else begin
            {r_cs_s1, r_cs_s2, r_cs_s3}    <= {bus.cs_i, r_cs_s1, r_cs_s2};
            {r_scl_s1, r_scl_s2, r_scl_s3} <= {bus.scl_i, r_scl_s1, r_scl_s2};
            {r_mosi_s1, r_mosi_s2}         <= {bus.mosi_i, r_mosi_s1};
            if (w_clr) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_shift) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], r_mosi_s2};
                r_cnt   <= (r_cnt == 5'd31) ? r_cnt : r_cnt + 5'd1;
            end
            r_err <= w_check && !w_good;
            r_ovr <= w_good && !w_load;
            r_upd <= w_dac_wr;
            if (w_load) begin
                r_cmd   <= w_cmd;
                r_addr  <= r_shift[DATA_BITS +: 4];
                r_data  <= w_data;
                r_valid <= 1'b1;
            end else if (r_valid && bus.frame_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_good && (w_cmd == 4'h1 || w_cmd == 4'h3)) r_input <= w_data;
            if (w_dac_wr) r_dac <= w_dac_nxt;
        end
    end

    assign bus.frame_valid_o = r_valid;
    assign bus.cmd_o         = r_cmd;
    assign bus.addr_o        = r_addr;
    assign bus.data_o        = r_data;
    assign bus.frame_err_o   = r_err;
    assign bus.overrun_o     = r_ovr;
    assign bus.dac_reg_o     = r_dac;
    assign bus.dac_update_o  = r_upd;
endmodule

// File: tb/tb_spi_dac_rx.sv
// tb_spi_dac_rx: directed SPI frames with a frame scoreboard and pulse counters.
module tb_spi_dac_rx;
    logic sys_clk_i = 1'b0;
    logic sys_rst   = 1'b1;
    int   checks = 0, failures = 0;
    int   n_acc = 0, n_vcyc = 0, n_err = 0, n_ovr = 0, n_upd = 0;
    logic [23:0] exp_q[$];
    logic [23:0] got, want;

    spi_dac_rx_if bus ();
    spi_dac_rx dut (.sys_clk_i(sys_clk_i), .sys_rst(sys_rst), .bus(bus));

    always #10 sys_clk_i = ~sys_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted frame must match the oldest expected one
    always @(negedge sys_clk_i) begin
        if (!sys_rst) begin
            if (bus.frame_valid_o) n_vcyc++;
            if (bus.frame_err_o) n_err++;
            if (bus.overrun_o) n_ovr++;
            if (bus.dac_update_o) n_upd++;
            if (bus.frame_valid_o && bus.frame_ready_i) begin
                n_acc++;
                got = {bus.cmd_o, bus.addr_o, bus.data_o};
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {8'h0, got}, 32'hFFFF_FFFF);
                end else begin
                    want = exp_q.pop_front();
                    chk("frame", {8'h0, got}, {8'h0, want});
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk_i);
        #1;
    endtask

    task automatic clr_cnt();
        n_acc = 0; n_vcyc = 0; n_err = 0; n_ovr = 0; n_upd = 0;
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.mosi_i = v[i];
            cyc(4);
            bus.scl_i = 1'b1;
            cyc(4);
            bus.scl_i = 1'b0;
        end
        cyc(4);
    endtask

    task automatic frame(input logic [31:0] v, input int n);
        bus.cs_i = 1'b0;
        cyc(4);
        spi_bits(v, n);
        bus.cs_i = 1'b1;
        cyc(10);
    endtask

    initial begin
        bus.cs_i = 1'b1; bus.scl_i = 1'b0; bus.mosi_i = 1'b0; bus.ldac_i = 1'b1; bus.frame_ready_i = 1'b1;
        cyc(5);
        chk("rst_valid", {31'h0, bus.frame_valid_o}, 0);
        chk("rst_cmd", {28'h0, bus.cmd_o}, 0);
        chk("rst_addr", {28'h0, bus.addr_o}, 0);
        chk("rst_data", {16'h0, bus.data_o}, 0);
        chk("rst_err", {31'h0, bus.frame_err_o}, 0);
        chk("rst_ovr", {31'h0, bus.overrun_o}, 0);
        chk("rst_dac", {16'h0, bus.dac_reg_o}, 0);
        chk("rst_upd", {31'h0, bus.dac_update_o}, 0);
        sys_rst = 1'b0;
        cyc(5);

        clr_cnt();
        exp_q.push_back(24'h04E6B7);
        frame(24'h04E6B7, 24);
        chk("plain_acc", n_acc, 1);
        chk("plain_vcyc", n_vcyc, 1);
        chk("plain_dac", {16'h0, bus.dac_reg_o}, 0);
        chk("plain_upd", n_upd, 0);

        clr_cnt();
        exp_q.push_back(24'h101234);
        frame(24'h101234, 24);
        chk("cmd1_dac", {16'h0, bus.dac_reg_o}, 0);
        chk("cmd1_upd", n_upd, 0);
        exp_q.push_back(24'h200000);
        frame(24'h200000, 24);
        chk("cmd2_dac", {16'h0, bus.dac_reg_o}, 32'h1234);
        chk("cmd2_upd", n_upd, 1);
        chk("cmd2_acc", n_acc, 2);

        clr_cnt();
        frame(32'h3FFFFF, 23);
        chk("short_err", n_err, 1);
        frame(32'h1F0FFFF, 25);
        chk("long_err", n_err, 2);
        chk("bad_vcyc", n_vcyc, 0);
        chk("bad_dac", {16'h0, bus.dac_reg_o}, 32'h1234);
        chk("bad_upd", n_upd, 0);

        clr_cnt();
        bus.frame_ready_i = 1'b0;
        exp_q.push_back(24'h31AAAA);
        frame(24'h31AAAA, 24);
        frame(24'h325555, 24);
        chk("hold_valid", {31'h0, bus.frame_valid_o}, 1);
        chk("hold_cmd", {28'h0, bus.cmd_o}, 3);
        chk("hold_addr", {28'h0, bus.addr_o}, 1);
        chk("hold_data", {16'h0, bus.data_o}, 32'hAAAA);
        chk("ovr_count", n_ovr, 1);
        chk("ovr_dac", {16'h0, bus.dac_reg_o}, 32'h5555);
        chk("ovr_upd", n_upd, 2);
        bus.frame_ready_i = 1'b1;
        cyc(3);
        chk("drain_acc", n_acc, 1);
        chk("drain_valid", {31'h0, bus.frame_valid_o}, 0);

        bus.cs_i = 1'b0;
        cyc(4);
        spi_bits(32'h3FF, 10);
        sys_rst = 1'b1;
        cyc(2);
        sys_rst = 1'b0;
        clr_cnt();
        spi_bits(32'h3FFF, 14);
        bus.cs_i = 1'b1;
        cyc(10);
        chk("midrst_vcyc", n_vcyc, 0);
        chk("midrst_err", n_err, 0);
        chk("midrst_dac", {16'h0, bus.dac_reg_o}, 0);
        exp_q.push_back(24'h05C3C3);
        frame(24'h05C3C3, 24);
        chk("post_rst_acc", n_acc, 1);

`ifdef SPI_DAC_RX_LDAC_EN
        clr_cnt();
        exp_q.push_back(24'h10BEEF);
        frame(24'h10BEEF, 24);
        chk("ldac_pre_dac", {16'h0, bus.dac_reg_o}, 0);
        bus.ldac_i = 1'b0;
        cyc(4);
        bus.ldac_i = 1'b1;
        cyc(4);
        chk("ldac_dac", {16'h0, bus.dac_reg_o}, 32'hBEEF);
        chk("ldac_upd", n_upd, 1);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_dac_rx.md
# spi_dac_rx

SPI receiver for the 24-bit DAC write frames produced by our SPI DAC master (cs/scl/mosi/ldac). It oversamples the bus on the system clock and shifts in MSB-first frames. It decodes each frame into command, address and data, and presents the result on a valid/ready port. It also keeps a DAC-style input register and output register. It is used as the bus-functional DAC model in system sims and as the receive end on loopback boards.

## Interface
- FRAME_BITS, 24, bits per frame; fixed layout {cmd[3:0], addr[3:0], data[15:0]}.
- DATA_BITS, 16, data field width.
- sys_clk_i  in  1  system clock, 50 MHz; one clock domain.
- sys_rst  in  1  reset, synchronous, active-high.
- cs_i  in  1  chip select, active low, asynchronous to sys_clk_i.
- scl_i  in  1  serial clock, mode 0; sampled on rising edge; asynchronous.
- mosi_i  in  1  serial data, asynchronous.
- ldac_i  in  1  load-DAC strobe, active low, asynchronous.
- frame_ready_i  in  1  consumer accepts the frame.
- frame_valid_o  out  1  decoded frame available.
- cmd_o  out  4  frame bits [23:20].
- addr_o  out  4  frame bits [19:16].
- data_o  out  16  frame bits [15:0].
- frame_err_o  out  1  one-cycle pulse on a bad bit count.
- overrun_o  out  1  one-cycle pulse when a good frame is dropped.
- dac_reg_o  out  16  DAC output register.
- dac_update_o  out  1  one-cycle pulse when dac_reg_o changes source.

## Operation
- cs_i, scl_i, mosi_i and ldac_i each pass through a 2-FF synchronizer. A third register provides edge detection.
- State machine:
  - WAIT_HI: entered on reset. Go to IDLE when synchronized cs is high.
  - IDLE: on cs falling edge, clear the shift register and bit counter, then go to SHIFT.
  - SHIFT: on each scl rising edge, shift in mosi (MSB first) and increment the counter. The counter saturates at 31. On cs rising edge, go to CHECK.
  - CHECK: runs for one cycle, then returns to IDLE.
- CHECK with count == 24 is a good frame:
  - If frame_valid_o is 0, or frame_valid_o & frame_ready_i are both high this cycle: load cmd_o, addr_o and data_o, and set frame_valid_o.
  - Otherwise pulse overrun_o. The held frame is kept and the new frame is dropped.
- CHECK with count != 24 (including 0 and more than 24): pulse frame_err_o. The frame is discarded and no register changes.
- frame_valid_o clears on frame_valid_o & frame_ready_i when no new load happens in that cycle. Outputs stay stable while valid is high and ready is low.
- DAC register commands, applied on a good frame regardless of handshake state:
  - cmd 0x1: input_reg <= data.
  - cmd 0x2: dac_reg <= input_reg.
  - cmd 0x3: input_reg <= data and dac_reg <= data.
  - Any other cmd leaves both registers unchanged.
  - Every dac_reg write pulses dac_update_o.
- scl edges while cs is high are ignored.

## Timing
- Reset values: all outputs 0, input_reg 0, state WAIT_HI.
- Bus requirement: scl high and low times are each ≥ 2 sys_clk_i periods. The cs setup to the first scl edge and the last scl edge to cs rise are each ≥ 3 sys_clk_i periods. A 25 MHz scl is out of specification.
- Bit sample: mosi is sampled in the synchronized cycle where the scl rising edge is detected, 3 sys_clk_i cycles after the pin edge. mosi must be held ≥ 3 cycles after the scl rise.
- Frame latency: frame_valid_o, frame_err_o and overrun_o assert 4 cycles after the cs_i rising edge at the pin, which is the cycle after CHECK.
- dac_update_o and the dac_reg_o change occur in the same cycle as frame_valid_o.
- Reset asserted mid-frame: the current frame is lost, all outputs are cleared, and the state returns to WAIT_HI. The remaining bits are ignored until cs is seen high.
- The minimum cs high time between frames is 2 cycles.

## Configuration
- SPI_DAC_RX_LDAC_EN defined:
  - A synchronized ldac_i falling edge copies input_reg to dac_reg and pulses dac_update_o.
  - If this coincides with a good-frame dac_reg write, the frame command wins and only one pulse is issued.
- SPI_DAC_RX_LDAC_EN undefined:
  - ldac_i is ignored and its synchronizer is removed.
  - dac_reg changes only through cmd 0x2 and cmd 0x3.

## Test plan
- Send 24'h04E6B7 with frame_ready_i=1 -> cmd_o=0x0, addr_o=0x4, data_o=0xE6B7, one frame_valid_o cycle, dac_reg_o unchanged at 0.
- Send 24'h1_0_1234, then 24'h2_0_0000 -> after the first frame dac_reg_o=0; after the second frame dac_reg_o=0x1234 with one dac_update_o pulse.
- Send 23-bit and 25-bit frames -> one frame_err_o pulse each, no frame_valid_o, registers unchanged.
- Hold frame_ready_i=0 and send 24'h3_1_AAAA then 24'h3_2_5555 -> outputs hold 0x3/0x1/0xAAAA, overrun_o pulses once, dac_reg_o=0x5555.
- Assert sys_rst after 10 bits of a frame, release it while cs is still low, and finish the frame -> no valid/err pulses. The next full frame decodes correctly.
- With SPI_DAC_RX_LDAC_EN: cmd 0x1 data 0xBEEF, then an ldac_i low pulse of 4 cycles -> dac_reg_o=0xBEEF with one dac_update_o pulse, about 3 cycles after the ldac_i fall.
